reg_bank_bist: RTL and testbench

REG_BANK_BIST -- requirements
Module: reg_bank_bist

---
 rtl/reg_bank_bist.sv | 191 +++++++++++++++++++
 tb/tb_reg_bank_bist.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_bist.sv
// reg_bank_bist: built-in self test for a 32 x 32-bit register bank.
// Writes a known pattern into every register, reads the bank back two
// registers per cycle and reports pass/fail, the first failing register
// and the number of mismatching reads. Register 0 is written with ZPAT
// to prove it is hardwired to zero.
module reg_bank_bist #(
  parameter int unsigned MULT = 12,
  parameter logic [31:0] ZPAT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic [31:0] WriteData,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_reg,
  output logic [5:0]  fail_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_nxt;
  logic [4:0]  w_idx_inc;

  // Next values of the registered outputs.
  logic [4:0]  w_write_register;
  logic        w_reg_write;
  logic [31:0] w_write_data;
  logic [4:0]  w_read_register1;
  logic [4:0]  w_read_register2;
  logic        w_busy;
  logic        w_done;
  logic        w_pass;
  logic [4:0]  w_fail_reg;
  logic [5:0]  w_fail_count;

  // Read-back comparison for the current pair.
  logic [4:0]  w_addr1;
  logic [4:0]  w_addr2;
  logic        w_miss1;
  logic        w_miss2;
  logic [6:0]  w_sum;
  logic [5:0]  w_fc_sat;

  // Pattern written to register idx (idx > 0), truncated to 32 bits.
  function automatic logic [31:0] f_pattern(input logic [4:0] idx);
    f_pattern = 32'(MULT) * {27'd0, idx};
  endfunction

  // Value a correct bank returns: register 0 always reads zero.
  function automatic logic [31:0] f_expect(input logic [4:0] idx);
    f_expect = (idx == 5'd0) ? 32'd0 : f_pattern(idx);
  endfunction

  assign w_idx_inc = r_idx + 5'd1;
  assign w_addr1   = {r_idx[3:0], 1'b0};
  assign w_addr2   = {r_idx[3:0], 1'b1};
  assign w_miss1   = (ReadData1 != f_expect(w_addr1));
  assign w_miss2   = (ReadData2 != f_expect(w_addr2));
  assign w_sum     = {1'b0, fail_count} + 7'(w_miss1) + 7'(w_miss2);
  // Saturate at 32 so the count can never wrap.
  assign w_fc_sat  = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];

  // Next-state and next-output decode; outputs are registered below so the
  // values computed here appear during the state being entered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_write_register = 5'd0;
    w_reg_write      = 1'b0;
    w_write_data     = 32'd0;
    w_read_register1 = 5'd0;
    w_read_register2 = 5'd0;
    w_busy           = 1'b0;
    w_done           = 1'b0;
    w_pass           = pass;
    w_fail_reg       = fail_reg;
    w_fail_count     = fail_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_WRITE;
          w_idx_nxt    = 5'd0;
          w_reg_write  = 1'b1;
          w_write_data = ZPAT;
          w_busy       = 1'b1;
          w_pass       = 1'b0;
          w_fail_reg   = 5'd0;
          w_fail_count = 6'd0;
        end
      end

      S_WRITE: begin
        w_busy = 1'b1;
        if (r_idx == 5'd31) begin
          w_state_nxt      = S_READ;
          w_idx_nxt        = 5'd0;
          w_read_register1 = 5'd0;
          w_read_register2 = 5'd1;
        end else begin
          w_idx_nxt        = w_idx_inc;
          w_reg_write      = 1'b1;
          w_write_register = w_idx_inc;
          w_write_data     = f_pattern(w_idx_inc);
        end
      end

      S_READ: begin
        w_fail_count = w_fc_sat;
        // Only the first mismatch of the run is recorded; port 1 wins a tie.
        if (fail_count == 6'd0) begin
          if (w_miss1)      w_fail_reg = w_addr1;
          else if (w_miss2) w_fail_reg = w_addr2;
        end
        if (r_idx == 5'd15) begin
          w_state_nxt = S_DONE;
          w_idx_nxt   = 5'd0;
          w_done      = 1'b1;
          w_pass      = (w_fc_sat == 6'd0);
        end else begin
          w_idx_nxt        = w_idx_inc;
          w_busy           = 1'b1;
          w_read_register1 = {w_idx_inc[3:0], 1'b0};
          w_read_register2 = {w_idx_inc[3:0], 1'b1};
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 5'd0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 5'd0;
      end
    endcase
  end

  // State, index and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 5'd0;
      WriteRegister <= 5'd0;
      RegWrite      <= 1'b0;
      WriteData     <= 32'd0;
      ReadRegister1 <= 5'd0;
      ReadRegister2 <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_reg      <= 5'd0;
      fail_count    <= 6'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      WriteRegister <= w_write_register;
      RegWrite      <= w_reg_write;
      WriteData     <= w_write_data;
      ReadRegister1 <= w_read_register1;
      ReadRegister2 <= w_read_register2;
      busy          <= w_busy;
      done          <= w_done;
      pass          <= w_pass;
      fail_reg      <= w_fail_reg;
      fail_count    <= w_fail_count;
    end
  end

endmodule

// File: tb/tb_reg_bank_bist.sv
// Directed testbench for reg_bank_bist with a behavioural register bank.
module tb_reg_bank_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_reg;
  logic [5:0]  fail_count;

  reg_bank_bist dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_reg      (fail_reg),
    .fail_count    (fail_count)
  );

  always #5 clk = ~clk;

  // Register bank model with fault injection.
  logic [31:0] bank [32];
  logic        c18 = 1'b0;     // register 18 reads 70
  logic        c27 = 1'b0;     // register 27 reads 0xDEAD
  logic        reg0_wr = 1'b0; // register 0 is writable

  function automatic logic [31:0] bank_rd(input logic [4:0] a);
    if (a == 5'd18 && c18)               bank_rd = 32'd70;
    else if (a == 5'd27 && c27)          bank_rd = 32'hDEAD;
    else if (a == 5'd0 && !reg0_wr)      bank_rd = 32'd0;
    else                                 bank_rd = bank[a];
  endfunction

  always @(posedge clk)
    if (RegWrite && (WriteRegister != 5'd0 || reg0_wr))
      bank[WriteRegister] <= WriteData;

  always_comb begin
    ReadData1 = bank_rd(ReadRegister1);
    ReadData2 = bank_rd(ReadRegister2);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Per-run observations.
  int          busy_n, rw_n, rw_bad, done_at;
  logic [31:0] wd_log [32];
  logic [4:0]  rr1_k5, rr2_k5;
  logic        pass_s, busy_at_done;
  logic [5:0]  fc_s;
  logic [4:0]  fr_s;

  function automatic logic [61:0] all_outs();
    all_outs = {WriteRegister, RegWrite, WriteData, ReadRegister1, ReadRegister2,
                busy, done, pass, fail_reg, fail_count};
  endfunction

  // Start a run with a one-cycle start pulse (called at a negedge), optionally
  // pulse start again at cycle pulse_at, and record what the run does.
  task automatic do_run(input int pulse_at);
    busy_n = 0; rw_n = 0; rw_bad = 0; done_at = 0;
    pass_s = 1'bx; fc_s = 'x; fr_s = 'x; busy_at_done = 1'bx;
    rr1_k5 = 'x; rr2_k5 = 'x;
    for (int i = 0; i < 32; i++) wd_log[i] = 'x;
    start = 1'b1;
    for (int c = 1; c <= 100 && done_at == 0; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (busy) begin
        if (RegWrite) begin
          rw_n++;
          if (busy_n >= 32) rw_bad++;
          wd_log[WriteRegister] = WriteData;
        end
        if (busy_n == 37) begin
          rr1_k5 = ReadRegister1;
          rr2_k5 = ReadRegister2;
        end
        busy_n++;
      end else if (RegWrite) begin
        rw_bad++;
      end
      if (done) begin
        done_at      = c;
        pass_s       = pass;
        fc_s         = fail_count;
        fr_s         = fail_reg;
        busy_at_done = busy;
      end
    end
    start = 1'b0;
    check("run_len", done_at, 49);
    check("busy_cycles", busy_n, 48);
    check("regwrite_cycles", rw_n, 32);
    check("regwrite_outside_write", rw_bad, 0);
    check("busy_at_done", busy_at_done, 0);
    @(negedge clk);
    check("done_single_cycle", {done, busy}, 0);
  endtask

  int dones, gap, found;

  initial begin
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_outs(), 0);

    // Clean bank: full passing run and write/read pattern.
    do_run(0);
    check("clean_pass", pass_s, 1);
    check("clean_fail_count", fc_s, 0);
    check("clean_fail_reg", fr_s, 0);
    check("wd_idx0", wd_log[0], 32'hFFFF_FFFF);
    check("wd_idx5", wd_log[5], 32'd60);
    check("wd_idx31", wd_log[31], 32'd372);
    check("rr1_k5", rr1_k5, 5'd10);
    check("rr2_k5", rr2_k5, 5'd11);
    check("pass_held_idle", pass, 1);

    // start pulsed during WRITE is ignored.
    do_run(10);
    check("pulse_pass", pass_s, 1);
    check("pulse_wd_idx31", wd_log[31], 32'd372);

    // Register 18 corrupted.
    c18 = 1'b1;
    do_run(0);
    check("r18_pass", pass_s, 0);
    check("r18_fail_count", fc_s, 1);
    check("r18_fail_reg", fr_s, 18);
    repeat (3) @(negedge clk);
    check("r18_result_held", {pass, fail_reg, fail_count}, {1'b0, 5'd18, 6'd1});

    // Registers 18 and 27 corrupted.
    c27 = 1'b1;
    do_run(0);
    check("r18_r27_pass", pass_s, 0);
    check("r18_r27_fail_count", fc_s, 2);
    check("r18_r27_fail_reg", fr_s, 18);
    c18 = 1'b0;
    c27 = 1'b0;

    // Register 0 writable.
    reg0_wr = 1'b1;
    do_run(0);
    check("r0_pass", pass_s, 0);
    check("r0_fail_count", fc_s, 1);
    check("r0_fail_reg", fr_s, 0);
    reg0_wr = 1'b0;

    // Reset during READ at pair 5.
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !RegWrite && ReadRegister1 == 5'd10) found = 1;
    end
    check("reach_pair5", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", all_outs(), 0);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_pass", pass, 0);
    do_run(0);
    check("post_reset_pass", pass_s, 1);

    // start held for 120 cycles: two complete runs, one-cycle IDLE gap.
    start = 1'b1;
    dones = 0;
    gap   = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done) dones++;
      else if (dones == 1 && !busy) gap++;
    end
    start = 1'b0;
    check("held_done_count", dones, 2);
    check("held_idle_gap", gap, 1);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("held_drain_done", found, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
